// File: rtl/key_event_ctrl.sv
// Per-key event generator downstream of the debouncer: press/release/click/long/repeat.
// `release` and `repeat` are SV keywords, so those outputs carry an _evt suffix.
module key_event_ctrl #(
    parameter int unsigned N_KEYS     = 4,
    parameter int unsigned CLK_PER_MS = 50000,
    parameter int unsigned LONG_MS    = 1000,
    parameter int unsigned REPEAT_MS  = 200
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [N_KEYS-1:0] key_v,
    input  logic              key_vld,
    output logic [N_KEYS-1:0] press,
    output logic [N_KEYS-1:0] release_evt,
    output logic [N_KEYS-1:0] click,
    output logic [N_KEYS-1:0] long_press,
    output logic [N_KEYS-1:0] repeat_evt,
    output logic [N_KEYS-1:0] held
);

    localparam int unsigned CW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int unsigned HW = $clog2(LONG_MS + 1);
    localparam int unsigned RW = (REPEAT_MS > 0) ? $clog2(REPEAT_MS + 1) : 1;

    localparam logic [CW-1:0] TICK_LAST = CW'(CLK_PER_MS - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_MS - 1);
    localparam logic [RW-1:0] REP_LAST  = (REPEAT_MS > 0) ? RW'(REPEAT_MS - 1) : '0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHORT = 2'd1;
    localparam logic [1:0] ST_LONG  = 2'd2;

    logic [CW-1:0]     tick_cnt_q, tick_cnt_d;
    logic              tick;
    logic [N_KEYS-1:0] k_q, k_d;
    logic [N_KEYS-1:0] key_dn, key_up;

    logic [1:0]    st_q   [N_KEYS];
    logic [1:0]    st_d   [N_KEYS];
    logic [HW-1:0] hold_q [N_KEYS];
    logic [HW-1:0] hold_d [N_KEYS];
    logic [RW-1:0] rep_q  [N_KEYS];
    logic [RW-1:0] rep_d  [N_KEYS];

    logic [N_KEYS-1:0] press_d, release_d, click_d, long_d, repeat_d;

    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + CW'(1);
    end

    assign key_dn = {N_KEYS{key_vld}} & k_q & ~key_v;
    assign key_up = {N_KEYS{key_vld}} & ~k_q & key_v;
    assign k_d    = key_vld ? key_v : k_q;
    assign held   = ~k_q;

    always_comb begin
        press_d   = '0;
        release_d = '0;
        click_d   = '0;
        long_d    = '0;
        repeat_d  = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            st_d[i]   = st_q[i];
            hold_d[i] = hold_q[i];
            rep_d[i]  = rep_q[i];
            case (st_q[i])
                ST_IDLE: begin
                    if (key_dn[i]) begin
                        st_d[i]    = ST_SHORT;
                        press_d[i] = 1'b1;
                        hold_d[i]  = '0;
                    end
                end
                ST_SHORT: begin
                    // A release in the same cycle as a tick takes priority.
                    if (key_up[i]) begin
                        st_d[i]      = ST_IDLE;
                        release_d[i] = 1'b1;
                        click_d[i]   = 1'b1;
                        hold_d[i]    = '0;
                    end else if (tick) begin
                        if (hold_q[i] == HOLD_LAST) begin
                            st_d[i]   = ST_LONG;
                            long_d[i] = 1'b1;
                            hold_d[i] = '0;
                            rep_d[i]  = '0;
                        end else begin
                            hold_d[i] = hold_q[i] + HW'(1);
                        end
                    end
                end
                ST_LONG: begin
                    if (key_up[i]) begin
                        st_d[i]      = ST_IDLE;
                        release_d[i] = 1'b1;
                        rep_d[i]     = '0;
                    end else if (tick && (REPEAT_MS > 0)) begin
                        if (rep_q[i] == REP_LAST) begin
                            repeat_d[i] = 1'b1;
                            rep_d[i]    = '0;
                        end else begin
                            rep_d[i] = rep_q[i] + RW'(1);
                        end
                    end
                end
                default: begin
                    st_d[i]   = ST_IDLE;
                    hold_d[i] = '0;
                    rep_d[i]  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tick_cnt_q  <= '0;
            k_q         <= '1;
            press       <= '0;
            release_evt <= '0;
            click       <= '0;
            long_press  <= '0;
            repeat_evt  <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                st_q[i]   <= ST_IDLE;
                hold_q[i] <= '0;
                rep_q[i]  <= '0;
            end
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            k_q         <= k_d;
            press       <= press_d;
            release_evt <= release_d;
            click       <= click_d;
            long_press  <= long_d;
            repeat_evt  <= repeat_d;
            for (int i = 0; i < N_KEYS; i++) begin
                st_q[i]   <= st_d[i];
                hold_q[i] <= hold_d[i];
                rep_q[i]  <= rep_d[i];
            end
        end
    end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl with a 10-cycle ms tick, LONG_MS=5, REPEAT_MS=2
// plus a second instance with repeat disabled.
module tb_key_event_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] key_v, key_v2;
    logic       key_vld, key_vld2;
    logic [3:0] press, rel_ev, click, long_press, rep_ev, held;
    logic [3:0] press2, rel_ev2, click2, long_press2, rep_ev2, held2;

    int total = 0;
    int bad   = 0;
    int ph;

    key_event_ctrl #(
        .N_KEYS(4), .CLK_PER_MS(10), .LONG_MS(5), .REPEAT_MS(2)
    ) dut (
        .clk(clk), .rstn(rstn), .key_v(key_v), .key_vld(key_vld),
        .press(press), .release_evt(rel_ev), .click(click),
        .long_press(long_press), .repeat_evt(rep_ev), .held(held)
    );

    key_event_ctrl #(
        .N_KEYS(4), .CLK_PER_MS(10), .LONG_MS(5), .REPEAT_MS(0)
    ) dut_norep (
        .clk(clk), .rstn(rstn), .key_v(key_v2), .key_vld(key_vld2),
        .press(press2), .release_evt(rel_ev2), .click(click2),
        .long_press(long_press2), .repeat_evt(rep_ev2), .held(held2)
    );

    always #5 clk = ~clk;

    // Prescaler phase as seen before the next edge; ph==9 means that edge is a tick.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) ph <= 0;
        else       ph <= (ph == 9) ? 0 : ph + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [3:0] v);
        key_v   = v;
        key_vld = 1'b1;
        step();
        key_vld = 1'b0;
    endtask

    task automatic strobe2(input logic [3:0] v);
        key_v2   = v;
        key_vld2 = 1'b1;
        step();
        key_vld2 = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; key_v = 4'hF; key_vld = 1'b0; key_v2 = 4'hF; key_vld2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({press, rel_ev, click, long_press, rep_ev, held} !== 24'h0) begin
            bad++;
            $display("FAIL reset_outs got=%h exp=0",
                     {press, rel_ev, click, long_press, rep_ev, held});
        end
        total++;
        if ({press2, rel_ev2, click2, long_press2, rep_ev2, held2} !== 24'h0) begin
            bad++;
            $display("FAIL reset_outs2 got=%h exp=0",
                     {press2, rel_ev2, click2, long_press2, rep_ev2, held2});
        end
        rstn = 1'b1;
        step();
        total++;
        if ({press, held} !== 8'h0) begin
            bad++; $display("FAIL reset_idle got=%h exp=00", {press, held});
        end
    endtask

    task automatic test_click();
        logic [3:0] any_long;
        strobe(4'b1110);
        total++;
        if (press !== 4'b0001) begin bad++; $display("FAIL t1_press got=%b exp=0001", press); end
        total++;
        if (held !== 4'b0001) begin bad++; $display("FAIL t1_held got=%b exp=0001", held); end
        step();
        total++;
        if (press !== 4'b0000) begin bad++; $display("FAIL t1_press_w got=%b exp=0000", press); end
        any_long = '0;
        for (int c = 0; c < 19; c++) begin
            step();
            any_long |= long_press | rep_ev;
        end
        total++;
        if (any_long !== 4'b0000) begin
            bad++; $display("FAIL t1_nolong got=%b exp=0000", any_long);
        end
        strobe(4'b1111);
        total++;
        if ({rel_ev, click} !== 8'b0001_0001) begin
            bad++; $display("FAIL t1_rel_click got=%b exp=00010001", {rel_ev, click});
        end
        total++;
        if ({held, long_press} !== 8'h00) begin
            bad++; $display("FAIL t1_held_off got=%b exp=00000000", {held, long_press});
        end
    endtask

    task automatic test_long_repeat();
        int ticks;
        logic is_t;
        logic [3:0] exp_l, exp_r;
        strobe(4'b1110);
        ticks = 0;
        for (int c = 0; c < 200 && ticks < 10; c++) begin
            is_t = (ph == 9);
            step();
            if (is_t) ticks++;
            exp_l = (is_t && ticks == 5) ? 4'b0001 : 4'b0000;
            exp_r = (is_t && (ticks == 7 || ticks == 9)) ? 4'b0001 : 4'b0000;
            total++;
            if ({long_press, rep_ev} !== {exp_l, exp_r}) begin
                bad++;
                $display("FAIL t2_long_rep tick=%0d got=%b exp=%b", ticks,
                         {long_press, rep_ev}, {exp_l, exp_r});
            end
        end
        total++;
        if (ticks != 10) begin bad++; $display("FAIL t2_timeout got=%0d exp=10", ticks); end
        strobe(4'b1111);
        total++;
        if ({rel_ev, click, held} !== 12'b0001_0000_0000) begin
            bad++;
            $display("FAIL t2_release got=%b exp=000100000000", {rel_ev, click, held});
        end
    endtask

    task automatic test_two_keys();
        int ticks;
        logic is_t;
        logic [3:0] exp_l;
        strobe(4'b0110);
        total++;
        if ({press, held} !== 8'b1001_1001) begin
            bad++; $display("FAIL t3_press got=%b exp=10011001", {press, held});
        end
        ticks = 0;
        for (int c = 0; c < 100 && ticks < 5; c++) begin
            is_t = (ph == 9);
            step();
            if (is_t) ticks++;
            exp_l = (is_t && ticks == 5) ? 4'b1001 : 4'b0000;
            total++;
            if (long_press !== exp_l) begin
                bad++;
                $display("FAIL t3_long tick=%0d got=%b exp=%b", ticks, long_press, exp_l);
            end
        end
        strobe(4'b1111);
        total++;
        if ({rel_ev, click} !== 8'b1001_0000) begin
            bad++; $display("FAIL t3_release got=%b exp=10010000", {rel_ev, click});
        end
    endtask

    task automatic test_release_on_tick();
        int ticks;
        logic is_t;
        logic [3:0] any_ev, exp_l;
        strobe(4'b1110);
        ticks = 0;
        for (int c = 0; c < 100 && ticks < 4; c++) begin
            is_t = (ph == 9);
            step();
            if (is_t) ticks++;
        end
        for (int c = 0; c < 20 && ph != 9; c++) step();
        total++;
        if (ph != 9) begin bad++; $display("FAIL t4_align got=%0d exp=9", ph); end
        strobe(4'b1111);
        total++;
        if ({rel_ev, click, long_press, held} !== 16'b0001_0001_0000_0000) begin
            bad++;
            $display("FAIL t4_rel_tick got=%b exp=0001000100000000",
                     {rel_ev, click, long_press, held});
        end
        any_ev = '0;
        for (int c = 0; c < 25; c++) begin
            step();
            any_ev |= long_press | rep_ev | press;
        end
        total++;
        if (any_ev !== 4'b0000) begin bad++; $display("FAIL t4_quiet got=%b exp=0000", any_ev); end
        strobe(4'b1110);
        total++;
        if (press !== 4'b0001) begin bad++; $display("FAIL t4_repress got=%b exp=0001", press); end
        ticks = 0;
        for (int c = 0; c < 100 && ticks < 5; c++) begin
            is_t = (ph == 9);
            step();
            if (is_t) ticks++;
            exp_l = (is_t && ticks == 5) ? 4'b0001 : 4'b0000;
            total++;
            if (long_press !== exp_l) begin
                bad++;
                $display("FAIL t4_long tick=%0d got=%b exp=%b", ticks, long_press, exp_l);
            end
        end
        strobe(4'b1111);
        total++;
        if ({rel_ev, click} !== 8'b0001_0000) begin
            bad++; $display("FAIL t4_release got=%b exp=00010000", {rel_ev, click});
        end
    endtask

    task automatic test_reset_mid_long();
        int ticks;
        logic is_t;
        logic [3:0] any_ev;
        strobe(4'b1110);
        ticks = 0;
        for (int c = 0; c < 100 && ticks < 6; c++) begin
            is_t = (ph == 9);
            step();
            if (is_t) ticks++;
        end
        rstn = 1'b0;
        #1;
        total++;
        if ({press, rel_ev, click, long_press, rep_ev, held} !== 24'h0) begin
            bad++;
            $display("FAIL t5_async got=%h exp=0",
                     {press, rel_ev, click, long_press, rep_ev, held});
        end
        step();
        step();
        rstn = 1'b1;
        any_ev = '0;
        for (int c = 0; c < 15; c++) begin
            step();
            any_ev |= press | held | long_press | rep_ev;
        end
        total++;
        if (any_ev !== 4'b0000) begin
            bad++; $display("FAIL t5_no_event got=%b exp=0000", any_ev);
        end
        strobe(4'b1110);
        total++;
        if ({press, held} !== 8'b0001_0001) begin
            bad++; $display("FAIL t5_fresh_press got=%b exp=00010001", {press, held});
        end
        strobe(4'b1111);
        total++;
        if ({rel_ev, click} !== 8'b0001_0001) begin
            bad++; $display("FAIL t5_click got=%b exp=00010001", {rel_ev, click});
        end
    endtask

    task automatic test_redundant();
        int ticks;
        int n_long;
        int n_rep;
        logic is_t;
        for (int c = 0; c < 4; c++) begin
            strobe(4'b1111);
            total++;
            if ({press, rel_ev, click, long_press, rep_ev, held} !== 24'h0) begin
                bad++;
                $display("FAIL t6_idle_strobe got=%h exp=0",
                         {press, rel_ev, click, long_press, rep_ev, held});
            end
        end
        strobe(4'b1110);
        strobe(4'b1110);
        total++;
        if ({press, held} !== 8'b0000_0001) begin
            bad++; $display("FAIL t6_dup_press got=%b exp=00000001", {press, held});
        end
        strobe(4'b1111);
        total++;
        if (rel_ev !== 4'b0001) begin bad++; $display("FAIL t6_rel got=%b exp=0001", rel_ev); end

        strobe2(4'b1110);
        total++;
        if (press2 !== 4'b0001) begin bad++; $display("FAIL t6_press2 got=%b exp=0001", press2); end
        ticks = 0; n_long = 0; n_rep = 0;
        for (int c = 0; c < 200 && ticks < 12; c++) begin
            is_t = (ph == 9);
            step();
            if (is_t) ticks++;
            if (long_press2[0]) n_long++;
            if (rep_ev2 != 4'b0000) n_rep++;
            if (is_t && ticks == 5) begin
                total++;
                if (long_press2 !== 4'b0001) begin
                    bad++; $display("FAIL t6_long2 got=%b exp=0001", long_press2);
                end
            end
        end
        total++;
        if (n_long != 1) begin bad++; $display("FAIL t6_long_count got=%0d exp=1", n_long); end
        total++;
        if (n_rep != 0) begin bad++; $display("FAIL t6_no_repeat got=%0d exp=0", n_rep); end
        strobe2(4'b1111);
        total++;
        if ({rel_ev2, click2} !== 8'b0001_0000) begin
            bad++; $display("FAIL t6_release2 got=%b exp=00010000", {rel_ev2, click2});
        end
    endtask

    initial begin
        test_reset();
        test_click();
        test_long_repeat();
        test_two_keys();
        test_release_on_tick();
        test_reset_mid_long();
        test_redundant();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
